// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line timing, bit-period derivation and
// receiver state encodings.
package uart_rx_pkg;

  localparam int unsigned CLK_FREQ_DEF = 32'd24000000;
  localparam int unsigned BAUD_DEF     = 32'd115200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; the reset value
// matches the input's idle level so no false edge appears after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled mid-bit sampling of a synchronized rx line,
// delivering bytes on a valid/ready stream with framing and overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned BAUD         = BAUD_DEF,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          rx_s;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          frame_err_q;
  logic          busy_q;
  logic          cnt_end_s;
  logic          load_s;

  logic [7:0]    m_data_q,  m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          overrun_q, overrun_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign cnt_end_s = (cnt_q == CNT_FULL);
  // Good frame: stop bit sampled high at its midpoint.
  assign load_s    = (state_q == ST_STOP) && cnt_end_s && rx_s;

  // Receive FSM with bit timing, shift register and error/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            if (!rx_s) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_end_s) begin
            cnt_q     <= '0;
            shreg_q   <= {rx_s, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_end_s) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        // A held-low line stays here so it cannot produce repeated frames.
        ST_BREAK: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          bit_idx_q <= 3'd0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: accept-and-load in one cycle is a legal transfer.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = 1'b0;
    if (load_s) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = shreg_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Register the stream outputs and the overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default timing (208 clocks per bit),
// using a byte scoreboard checked at every valid/ready handshake.
module tb_uart_rx;

  localparam int CPB = 208;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int hs_cnt  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int rise_cyc = 0;
  logic       mv_prev = 1'b0;
  logic       mr_prev = 1'b0;
  logic [7:0] md_prev = 8'h00;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst_n) begin
      if (m_valid && m_ready) begin
        hs_cnt++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_byte: got 0x%02h, required no byte", m_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (m_data !== exp_b) $display("FAIL byte_data: got 0x%02h, required 0x%02h", m_data, exp_b);
          else n_pass++;
        end
      end
      if (mv_prev && !mr_prev) begin
        n_total++;
        if (m_valid !== 1'b1 || m_data !== md_prev)
          $display("FAIL hold_stable: got valid=%b data=0x%02h, required valid=1 data=0x%02h", m_valid, m_data, md_prev);
        else n_pass++;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (frame_err === 1'b1 && overrun === 1'b1) begin
        n_total++;
        $display("FAIL flags_exclusive: got frame_err=1 overrun=1, required not both");
      end
      if (m_valid && !mv_prev) rise_cyc = cyc;
    end
    mv_prev <= m_valid;
    mr_prev <= m_ready;
    md_prev <= m_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic wait_hs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (hs_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; m_ready = 1'b0;
    tick(5);
    n_total++; if (m_data !== 8'h00) $display("FAIL reset_data: got 0x%02h, required 0x00", m_data); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", m_valid); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, required 0", frame_err); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, required 0", overrun); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single;
    int hs0, fe0, ov0, s, lat;
    bit ok;
    hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    m_ready = 1'b1;
    exp_q.push_back(8'h55);
    s = cyc;
    send_frame(8'h55, 1'b1);
    wait_hs(hs0 + 1, 500, ok);
    tick(50);
    lat = rise_cyc - s;
    n_total++; if (!ok) $display("FAIL single_timeout: got no handshake, required one"); else n_pass++;
    n_total++; if (lat < 1977 || lat > 1979) $display("FAIL single_latency: got %0d, required 1977..1979", lat); else n_pass++;
    n_total++; if (hs_cnt - hs0 !== 1) $display("FAIL single_count: got %0d, required 1", hs_cnt - hs0); else n_pass++;
    n_total++; if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL single_flags: got fe=%0d ov=%0d, required none", fe_cnt - fe0, ov_cnt - ov0); else n_pass++;
  endtask

  task automatic test_overrun;
    int hs0, ov0, fe0;
    hs0 = hs_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
    m_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    tick(20);
    n_total++; if (ov_cnt - ov0 !== 1) $display("FAIL overrun_count: got %0d, required 1", ov_cnt - ov0); else n_pass++;
    n_total++; if (m_valid !== 1'b1 || m_data !== 8'h55) $display("FAIL overrun_kept: got valid=%b data=0x%02h, required 1/0x55", m_valid, m_data); else n_pass++;
    n_total++; if (fe_cnt != fe0) $display("FAIL overrun_fe: got %0d, required 0", fe_cnt - fe0); else n_pass++;
    m_ready = 1'b1;
    tick(1);
    n_total++; if (m_valid !== 1'b0) $display("FAIL overrun_drain: got %b, required 0", m_valid); else n_pass++;
    n_total++; if (hs_cnt - hs0 !== 1) $display("FAIL overrun_hs: got %0d, required 1", hs_cnt - hs0); else n_pass++;
  endtask

  task automatic test_glitch;
    int hs0, fe0;
    bit saw_busy, ok;
    hs0 = hs_cnt; fe0 = fe_cnt; saw_busy = 1'b0;
    m_ready = 1'b1;
    rx = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick(1);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    n_total++; if (!saw_busy) $display("FAIL glitch_busy_seen: got 0, required 1"); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL glitch_idle: got busy=%b, required 0", busy); else n_pass++;
    n_total++; if (hs_cnt != hs0 || fe_cnt != fe0) $display("FAIL glitch_quiet: got hs=%0d fe=%0d, required 0/0", hs_cnt - hs0, fe_cnt - fe0); else n_pass++;
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b1);
    wait_hs(hs0 + 1, 500, ok);
    n_total++; if (!ok) $display("FAIL glitch_next_byte: got no handshake, required one"); else n_pass++;
  endtask

  task automatic test_break;
    int hs0, fe0, ov0, drops;
    bit ok;
    hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; drops = 0;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    for (int i = 0; i < 3 * CPB; i++) begin
      tick(1);
      if (busy !== 1'b1) drops++;
    end
    n_total++; if (drops != 0) $display("FAIL break_busy_held: got %0d low cycles, required 0", drops); else n_pass++;
    rx = 1'b1;
    tick(10);
    n_total++; if (busy !== 1'b0) $display("FAIL break_release: got busy=%b, required 0", busy); else n_pass++;
    n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL break_fe_count: got %0d, required 1", fe_cnt - fe0); else n_pass++;
    n_total++; if (hs_cnt != hs0 || ov_cnt != ov0) $display("FAIL break_no_byte: got hs=%0d ov=%0d, required 0/0", hs_cnt - hs0, ov_cnt - ov0); else n_pass++;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_hs(hs0 + 1, 500, ok);
    n_total++; if (!ok) $display("FAIL break_next_byte: got no handshake, required one"); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int hs0;
    bit ok;
    hs0 = hs_cnt;
    m_ready = 1'b1;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    rst_n = 1'b0;
    tick(2);
    n_total++; if (m_data !== 8'h00 || m_valid !== 1'b0) $display("FAIL midrst_stream: got data=0x%02h valid=%b, required 0x00/0", m_data, m_valid); else n_pass++;
    n_total++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL midrst_flags: got busy=%b fe=%b ov=%b, required 0/0/0", busy, frame_err, overrun); else n_pass++;
    tick(5);
    rst_n = 1'b1;
    tick(3 * CPB);
    n_total++; if (hs_cnt != hs0 || busy !== 1'b0) $display("FAIL midrst_no_byte: got hs=%0d busy=%b, required 0/0", hs_cnt - hs0, busy); else n_pass++;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_hs(hs0 + 1, 500, ok);
    n_total++; if (!ok) $display("FAIL midrst_next_byte: got no handshake, required one"); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int hs0, fe0, ov0;
    bit ok;
    hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    m_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    wait_hs(hs0 + 16, 500, ok);
    tick(20);
    n_total++; if (!ok || hs_cnt - hs0 !== 16) $display("FAIL stream_count: got %0d, required 16", hs_cnt - hs0); else n_pass++;
    n_total++; if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL stream_flags: got fe=%0d ov=%0d, required 0/0", fe_cnt - fe0, ov_cnt - ov0); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL stream_leftover: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_overrun;
    test_glitch;
    test_break;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage of the serial design. Converts the asynchronous `rx` line (8N1, LSB first) into bytes delivered on a valid/ready stream.
- Feeds the byte-processing/loopback logic in the top level, which drives the transmitter.
- Default timing is 24 MHz clock, 115200 baud.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 24000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 208): clocks per bit; must be ≥ 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous serial input; idle high.
- m_data  out  8  received byte; held stable while m_valid=1.
- m_valid  out  1  byte available.
- m_ready  in  1  consumer accepts byte when m_valid&m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte dropped because output register still full.
- busy  out  1  high while state ≠ IDLE.

Interface (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low; the polarity and synchronicity are fixed.

Behaviour:
- Reset values: m_data=0x00, m_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchronizer FFs=1, counters=0.
- Asserting rst_n mid-frame aborts the frame immediately, with no partial byte and no flags.
- `rx` passes through a 2-FF synchronizer (rx_s) before any use. The FSM never looks at raw `rx`.
- IDLE: when rx_s==0, go to START and clear bit_cnt.
- START: count to CLKS_PER_BIT/2−1 (103), which is mid start bit. Sample rx_s there.
  - rx_s==0: go to DATA and clear bit_cnt and bit_idx.
  - rx_s==1: false start (glitch). Return to IDLE; no flag.
- DATA: count to CLKS_PER_BIT−1, then sample rx_s into shreg: shreg = {rx_s, shreg[7:1]}.
  - bit_idx increments 0..7.
  - After the sample with bit_idx==7, go to STOP.
- STOP: count to CLKS_PER_BIT−1, then sample rx_s.
  - rx_s==1 (good frame): offer shreg to the output register (rules below). Go to IDLE.
  - rx_s==0 (bad frame): pulse frame_err for one cycle, discard the byte, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line must not generate repeated frames.
- Output register, with load = good-frame event this cycle:
  - load && (!m_valid || m_ready): m_data<=shreg, m_valid<=1.
  - load && m_valid && !m_ready: old byte kept, new byte dropped, overrun pulses for one cycle.
  - !load && m_valid && m_ready: m_valid<=0.
- Simultaneous accept and load is a legal back-to-back transfer; m_valid stays 1 with the new data.
- Latency: m_valid rises 1978 ±1 clk after the falling edge of `rx` at defaults. This is 2 (sync) + 104 (half start bit) + 1664 (8 data bits) + 208 (stop bit).
  - The delivery point is mid stop bit, so the next start bit can be detected without loss.
- frame_err and overrun are registered, single-cycle, never both in the same cycle.
- Counter width is $clog2(CLKS_PER_BIT). bit_idx is 3 bits.

Decomposition:
- Shared header `uart_pkg.vh` holds:
  - default CLK_FREQ and BAUD;
  - the CLKS_PER_BIT derivation;
  - FSM state encodings (IDLE, START, DATA, STOP, BREAK; 3-bit).
- The transmitter reuses the same header.
- One natural sub-module is `sync_2ff` (parameterised reset value, here 1). The receiver and any other async inputs reuse it.
- Everything else stays in uart_rx.

Test Plan:
1. Reset, rx=1, send 0x55 at 115200 baud, m_ready=1 → m_valid pulses once ~1978 clk after the start edge, m_data=0x55, no flags.
2. Send 0x55 then 0xAA back-to-back, m_ready=0 until after the second stop bit → m_data stays 0x55, overrun pulses once at the 0xAA stop sample. Then m_ready=1 → m_valid drops next cycle.
3. Drive a 2 µs low glitch on rx → busy briefly high, returns to IDLE, no m_valid, no frame_err. A following 0xAA is received correctly.
4. Send 0xA5 with stop bit 0, then hold rx low for 3 bit times, then high → one frame_err pulse, no m_valid, busy held high until rx returns high. A next byte 0x3C is received correctly.
5. Assert rst_n low in the middle of data bit 4 of 0xFF, release it, send 0x12 → all outputs at reset values during reset, no spurious byte, then m_data=0x12.
6. Stream 16 bytes 0x00..0x0F with m_ready tied 1 and no idle between frames → 16 m_valid handshakes in order, values correct, zero flags.
